// File: rtl/led_show_pkg.sv
// Shared types and pass-length helpers for the LED show sequencer.
// LED_SHOW_BLINK_EN compiles in the BLINK mode.
package led_show_pkg;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        FILL   = 2'd1,
        BLINK  = 2'd2,
        RSVD   = 2'd3
    } show_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } show_state_t;

    localparam int BLINK_PASS_LEN = 2;

    function automatic int bounce_pass_len(input int n_led);
        return 2 * (n_led - 1);
    endfunction

    function automatic int fill_pass_len(input int n_led);
        return n_led + 1;
    endfunction

    function automatic logic mode_ok(input show_mode_t m);
`ifdef LED_SHOW_BLINK_EN
        return (m == BOUNCE) || (m == FILL) || (m == BLINK);
`else
        return (m == BOUNCE) || (m == FILL);
`endif
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Base-tick prescaler plus speed-scaled step counter.
// step is a one-cycle pulse on the tick that reaches the limit.
module led_step_timer #(
    parameter int N_SPEED  = 8,
    parameter int TICK_DIV = 400000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [N_SPEED-1:0] speed,
    output logic               step
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]      presc;
    logic [N_SPEED-1:0] step_cnt;
    logic [N_SPEED-1:0] limit;
    logic               tick;
    logic               hit;

    // all-ones speed gives limit 0, i.e. one step per base tick
    assign limit = ~speed;
    assign tick  = (presc == PW'(TICK_DIV - 1));
    assign hit   = (step_cnt >= limit);
    assign step  = tick && hit && !clear;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc    <= '0;
            step_cnt <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                step_cnt <= hit ? '0 : step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_show_scheduler.sv
// LED show sequencer: bounce/fill/blink patterns for a number of passes.
// BLINK is only present when LED_SHOW_BLINK_EN is defined.
module led_show_scheduler
    import led_show_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int N_SPEED  = 8,
    parameter int TICK_DIV = 400000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [7:0]         cmd_repeat,
    input  logic [N_SPEED-1:0] speed,
    input  logic               abort,
    output logic [N_LED-1:0]   leds,
    output logic               busy,
    output logic               done
);

    show_state_t      state, state_n;
    show_mode_t       mode, mode_n;
    logic [7:0]       rep, rep_n;
    logic [7:0]       pass_cnt, pass_n;
    logic             dir, dir_n, dir_step;
    logic [N_LED-1:0] leds_n, pat;
    logic             pass_end;
    logic             step;

    led_step_timer #(
        .N_SPEED (N_SPEED),
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(state != RUN),
        .speed(speed),
        .step (step)
    );

    assign cmd_ready = (state == IDLE);

    // next frame if a step occurs now; dir 0 = moving toward the MSB
    always_comb begin
        pat      = leds;
        pass_end = 1'b0;
        dir_step = dir;
        unique case (mode)
            BOUNCE: begin
                if (!dir) begin
                    pat = leds << 1;
                    if (pat[N_LED-1]) dir_step = 1'b1;
                end else begin
                    pat = leds >> 1;
                    if (pat[0]) begin
                        dir_step = 1'b0;
                        pass_end = 1'b1;
                    end
                end
            end
            FILL: begin
                if (&leds) begin
                    pat      = '0;
                    pass_end = 1'b1;
                end else begin
                    pat = {leds[N_LED-2:0], 1'b1};
                end
            end
`ifdef LED_SHOW_BLINK_EN
            BLINK: begin
                pat      = ~leds;
                pass_end = &leds;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode;
        rep_n   = rep;
        pass_n  = pass_cnt;
        dir_n   = dir;
        leds_n  = leds;
        unique case (state)
            IDLE: begin
                leds_n = '0;
                if (cmd_valid) begin
                    mode_n  = show_mode_t'(cmd_mode);
                    rep_n   = cmd_repeat;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                pass_n = '0;
                dir_n  = 1'b0;
                if (abort || !mode_ok(mode)) begin
                    leds_n  = '0;
                    state_n = FINISH;
                end else begin
                    leds_n  = (mode == BOUNCE) ? N_LED'(1) : '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    leds_n  = '0;
                    state_n = FINISH;
                end else if (step) begin
                    leds_n = pat;
                    dir_n  = dir_step;
                    if (pass_end) begin
                        pass_n = pass_cnt + 8'd1;
                        if (rep != 8'd0 && pass_n == rep) begin
                            leds_n  = '0;
                            state_n = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                leds_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mode     <= BOUNCE;
            rep      <= '0;
            pass_cnt <= '0;
            dir      <= 1'b0;
            leds     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            rep      <= rep_n;
            pass_cnt <= pass_n;
            dir      <= dir_n;
            leds     <= leds_n;
            busy     <= (state_n == LOAD) || (state_n == RUN);
            done     <= (state_n == FINISH);
        end
    end

endmodule
